// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Define BOOTH_MULT_ACC_EN to add the acc port (p_new = p_old + a*b).
module booth_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
`ifdef BOOTH_MULT_ACC_EN
  input  logic               acc,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);
  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW = $clog2(ITER + 1);
  localparam int PW = 2 * WIDTH;
  if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_mult_seq: WIDTH must be even and >= 4");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] acc_q, acc_d, mcand_q, mcand_d, p_q, p_d, pp, sum;
  logic [WIDTH+2:0] mult_q, mult_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, sa, sb, acc_en;
`ifdef BOOTH_MULT_ACC_EN
  assign acc_en = acc;
`else
  assign acc_en = 1'b0;
`endif
  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign out_valid = (state_q == DONE);
  assign p = p_q;
  assign accept = in_valid && in_ready;
  assign sa = signed_mode & a[WIDTH-1];
  assign sb = signed_mode & b[WIDTH-1];
  // The multiplicand shifts left two places per digit, so the modulo-2^PW sum stays exact.
  always_comb begin
    case (mult_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end
  assign sum = acc_q + pp;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mult_d = mult_q;
    cnt_d = cnt_q;
    p_d = p_q;
    if (accept) begin
      state_d = BUSY;
      acc_d = acc_en ? p_q : '0;
      mcand_d = {{WIDTH{sa}}, a};
      mult_d = {sb, sb, b, 1'b0};
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      acc_d = sum;
      mcand_d = mcand_q << 2;
      mult_d = mult_q >> 2;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(ITER - 1)) begin
        state_d = DONE;
        p_d = sum;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      mcand_q <= '0;
      mult_q <= '0;
      cnt_q <= '0;
      p_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mult_q <= mult_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed and random checks of booth_mult_seq (WIDTH=16) against an arithmetic model.
module tb_booth_mult_seq;
  localparam int ITER = 9;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, signed_mode = 1'b0;
  logic out_valid, out_ready = 1'b1, acc = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [31:0] p, model_p = '0;
  int total = 0, bad = 0;
  booth_mult_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode),
`ifdef BOOTH_MULT_ACC_EN
    .acc(acc),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic sm);
    logic [63:0] ex, ey, pr;
    ex = sm ? {{48{x[15]}}, x} : {48'b0, x};
    ey = sm ? {{48{y[15]}}, y} : {48'b0, y};
    pr = ex * ey;
    return pr[31:0];
  endfunction
  task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic sm, input logic ac, input logic ordy);
    @(negedge clk);
    a = x; b = y; signed_mode = sm; acc = ac; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("in_ready_at_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = ordy;
    a = $urandom; b = $urandom; signed_mode = $urandom;
    model_p = (ac ? model_p : 32'h0) + ref_mul(x, y, sm);
  endtask
  task automatic await(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!out_valid && n < 40);
    check({tag, "_latency"}, n, ITER);
    check({tag, "_p"}, p, model_p);
  endtask
  task automatic mul(input logic [15:0] x, input logic [15:0] y, input logic sm, input logic ac, input logic ordy, input string tag);
    launch(x, y, sm, ac, ordy);
    await(tag);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 0);
    @(negedge clk) rst = 1'b0;
    mul(16'h8000, 16'h8000, 1, 0, 1, "sx_min");
    check("sx_min_lit", p, 32'h40000000);
    mul(16'hFFFF, 16'h0002, 1, 0, 1, "sx_neg");
    check("sx_neg_lit", p, 32'hFFFFFFFE);
    mul(16'hFFFF, 16'hFFFF, 0, 0, 1, "umax");
    check("umax_lit", p, 32'hFFFE0001);
    mul(16'h1234, 16'h0000, 0, 0, 1, "uzero");
    check("uzero_lit", p, 32'h0);
    mul(16'd3, -16'sd7, 1, 0, 0, "bp");
    check("bp_lit", p, 32'hFFFFFFEB);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_p", p, 32'hFFFFFFEB);
      check("bp_hold_ready", in_ready, 0);
    end
    launch(16'd5, 16'd6, 0, 0, 1);
    check("b2b_busy", out_valid, 0);
    check("b2b_p_kept", p, 32'hFFFFFFEB);
    await("b2b");
    check("b2b_lit", p, 32'h1E);
    launch(16'd100, 16'd200, 0, 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    model_p = '0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_p", p, 0);
    rst = 1'b0;
    mul(16'd2, 16'd3, 0, 0, 1, "after_abort");
    check("after_abort_lit", p, 32'd6);
`ifdef BOOTH_MULT_ACC_EN
    mul(16'd10, 16'd10, 1, 0, 1, "acc0");
    check("acc0_lit", p, 32'h64);
    mul(16'd3, -16'sd4, 1, 1, 1, "acc1");
    check("acc1_lit", p, 32'h58);
`endif
    for (int i = 0; i < 40; i++) begin
      logic ac;
`ifdef BOOTH_MULT_ACC_EN
      ac = 1'($urandom);
`else
      ac = 1'b0;
`endif
      mul(16'($urandom), 16'($urandom), 1'($urandom), ac, 1'($urandom), "rnd");
      if (!out_ready) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("rnd_hold_p", p, model_p);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
